// File: rtl/instruction_fetch_controller.sv
// Two-byte instruction fetch sequencer: reads low then high byte at the PC into the IR.
// Optional memory-wait abort is enabled by defining FETCH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for fetch_req, pc_load allowed
// REQ_LO | reading low byte at pc
// REQ_HI | reading high byte at pc
// DONE   | one-cycle fetch_done pulse
module instruction_fetch_controller #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   input  logic [7:0]  mem_data,
   input  logic        mem_valid,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   output logic        ir_write,
   output logic        ir_high_sel,
   output logic [7:0]  ir_data,
   output logic        busy,
   output logic        fetch_done,
   output logic        fetch_error
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ_LO = 2'd1;
   localparam logic [1:0] S_REQ_HI = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] start_pc_q, start_pc_d;
   logic        in_req;
   logic        abort;

   assign in_req = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   // Abort wins over a late mem_valid in the same cycle, so no IR write happens.
   assign abort = in_req && (wait_cnt_q == CW'(TIMEOUT_CYCLES));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if ((state_d != state_q) || !in_req) begin
         wait_cnt_d = '0;
      end else if (!mem_valid) begin
         wait_cnt_d = wait_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      start_pc_d = start_pc_q;
      case (state_q)
         S_IDLE: begin
            if (pc_load) begin
               pc_d = pc_load_value;
            end else if (fetch_req) begin
               start_pc_d = pc_q;
               state_d    = S_REQ_LO;
            end
         end
         S_REQ_LO, S_REQ_HI: begin
            if (abort) begin
               pc_d    = start_pc_q;
               state_d = S_IDLE;
            end else if (mem_valid) begin
               pc_d    = pc_q + 16'd1;
               state_d = (state_q == S_REQ_LO) ? S_REQ_HI : S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= 16'h0000;
         start_pc_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         start_pc_q <= start_pc_d;
      end
   end

   assign mem_rd      = in_req;
   assign mem_addr    = pc_q;
   assign ir_write    = in_req && mem_valid && !abort;
   assign ir_high_sel = (state_q == S_REQ_HI);
   assign ir_data     = mem_data;
   assign busy        = (state_q != S_IDLE);
   assign fetch_done  = (state_q == S_DONE);
   assign fetch_error = abort;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed self-checking bench for instruction_fetch_controller.
// The timeout scenario is compiled only when FETCH_TIMEOUT_EN is defined.
module tb_instruction_fetch_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_load_value = 16'h0000;
   logic [7:0]  mem_data = 8'h00;
   logic        mem_valid = 1'b0;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        ir_write;
   logic        ir_high_sel;
   logic [7:0]  ir_data;
   logic        busy;
   logic        fetch_done;
   logic        fetch_error;

   int checks = 0;
   int errors = 0;

   instruction_fetch_controller #(.TIMEOUT_CYCLES(15)) dut (
      .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_load_value(pc_load_value), .mem_data(mem_data), .mem_valid(mem_valid),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .ir_write(ir_write), .ir_high_sel(ir_high_sel),
      .ir_data(ir_data), .busy(busy), .fetch_done(fetch_done), .fetch_error(fetch_error)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic load_pc(input logic [15:0] v);
      pc_load = 1'b1; pc_load_value = v;
      tick();
      pc_load = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #12;
      checks++; if ({mem_rd, ir_write, ir_high_sel, busy, fetch_done, fetch_error} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs got %b exp 000000", {mem_rd, ir_write, ir_high_sel, busy, fetch_done, fetch_error});
      end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || mem_addr !== 16'h0000) begin
         errors++; $display("FAIL post_reset got busy=%b addr=%h exp 0/0000", busy, mem_addr);
      end
   endtask

   task automatic test_basic;
      reset = 1'b1; #3; reset = 1'b0;
      tick();
      load_pc(16'h0100);
      #1;
      checks++; if (mem_addr !== 16'h0100 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_load got addr=%h busy=%b exp 0100/0", mem_addr, busy);
      end
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0; mem_valid = 1'b1; mem_data = 8'hA5;
      #1;
      checks++; if ({mem_rd, ir_write, ir_high_sel, busy, fetch_done} !== 5'b11010 || ir_data !== 8'hA5 || mem_addr !== 16'h0100) begin
         errors++; $display("FAIL basic_lo got rd/wr/hs/busy/done=%b data=%h addr=%h exp 11010/a5/0100",
                            {mem_rd, ir_write, ir_high_sel, busy, fetch_done}, ir_data, mem_addr);
      end
      tick();
      mem_data = 8'h3C;
      #1;
      checks++; if ({mem_rd, ir_write, ir_high_sel, busy, fetch_done} !== 5'b11110 || ir_data !== 8'h3C || mem_addr !== 16'h0101) begin
         errors++; $display("FAIL basic_hi got rd/wr/hs/busy/done=%b data=%h addr=%h exp 11110/3c/0101",
                            {mem_rd, ir_write, ir_high_sel, busy, fetch_done}, ir_data, mem_addr);
      end
      tick();
      #1;
      checks++; if (fetch_done !== 1'b1 || ir_write !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b1 || mem_addr !== 16'h0102) begin
         errors++; $display("FAIL basic_done got done=%b wr=%b rd=%b busy=%b addr=%h exp 1/0/0/1/0102",
                            fetch_done, ir_write, mem_rd, busy, mem_addr);
      end
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL basic_no_error got %b exp 0", fetch_error); end
      tick();
      mem_valid = 1'b0;
      #1;
      checks++; if (fetch_done !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0102) begin
         errors++; $display("FAIL basic_idle got done=%b busy=%b addr=%h exp 0/0/0102", fetch_done, busy, mem_addr);
      end
   endtask

   task automatic test_wrap;
      load_pc(16'hFFFF);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0; mem_valid = 1'b1;
      #1;
      checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_lo_addr got %h exp ffff", mem_addr); end
      tick();
      #1;
      checks++; if (mem_addr !== 16'h0000 || ir_high_sel !== 1'b1) begin
         errors++; $display("FAIL wrap_hi_addr got addr=%h hs=%b exp 0000/1", mem_addr, ir_high_sel);
      end
      tick();
      #1;
      checks++; if (mem_addr !== 16'h0001 || fetch_done !== 1'b1) begin
         errors++; $display("FAIL wrap_done got addr=%h done=%b exp 0001/1", mem_addr, fetch_done);
      end
      tick();
      mem_valid = 1'b0;
   endtask

   task automatic test_wait_states;
      logic        exp_rd, exp_wr, exp_done;
      logic [15:0] exp_addr;
      load_pc(16'h0200);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         mem_valid = (c == 5) || (c == 10);
         mem_data  = (c <= 5) ? 8'h11 : 8'h22;
         #1;
         exp_rd   = (c <= 10);
         exp_wr   = (c == 5) || (c == 10);
         exp_done = (c == 11);
         exp_addr = (c <= 5) ? 16'h0200 : ((c <= 10) ? 16'h0201 : 16'h0202);
         checks++; if (mem_rd !== exp_rd || ir_write !== exp_wr || fetch_done !== exp_done || mem_addr !== exp_addr) begin
            errors++; $display("FAIL wait_cycle%0d got rd=%b wr=%b done=%b addr=%h exp %b/%b/%b/%h",
                               c, mem_rd, ir_write, fetch_done, mem_addr, exp_rd, exp_wr, exp_done, exp_addr);
         end
         if (exp_wr) begin
            checks++; if (ir_high_sel !== (c == 10)) begin
               errors++; $display("FAIL wait_hs%0d got %b exp %b", c, ir_high_sel, (c == 10));
            end
         end
         tick();
      end
      mem_valid = 1'b0;
   endtask

   task automatic test_priority;
      pc_load = 1'b1; pc_load_value = 16'h0300; fetch_req = 1'b1;
      tick();
      pc_load = 1'b0; fetch_req = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || mem_addr !== 16'h0300) begin
         errors++; $display("FAIL prio_load got busy=%b addr=%h exp 0/0300", busy, mem_addr);
      end
      fetch_req = 1'b1;
      tick();
      pc_load = 1'b1; pc_load_value = 16'h1234; mem_valid = 1'b0;
      tick();
      mem_valid = 1'b1;
      #1;
      checks++; if (mem_addr !== 16'h0300 || busy !== 1'b1) begin
         errors++; $display("FAIL prio_ignore_load got addr=%h busy=%b exp 0300/1", mem_addr, busy);
      end
      tick();
      fetch_req = 1'b0; pc_load = 1'b0;
      tick();
      mem_valid = 1'b0;
      tick();
      #1;
      checks++; if (busy !== 1'b0 || mem_addr !== 16'h0302 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL prio_no_second got busy=%b addr=%h rd=%b exp 0/0302/0", busy, mem_addr, mem_rd);
      end
   endtask

   task automatic test_reset_mid;
      logic seen_done;
      load_pc(16'h0500);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0; mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || mem_addr !== 16'h0000 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL midrst_async got busy=%b addr=%h rd=%b exp 0/0000/0", busy, mem_addr, mem_rd);
      end
      tick();
      reset = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (fetch_done || fetch_error || busy) seen_done = 1'b1;
         tick();
      end
      checks++; if (seen_done !== 1'b0 || mem_addr !== 16'h0000) begin
         errors++; $display("FAIL midrst_abandon got pulse_or_busy=%b addr=%h exp 0/0000", seen_done, mem_addr);
      end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout;
      load_pc(16'h0040);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0; mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
      for (int c = 0; c < 15; c++) begin
         #1;
         checks++; if (fetch_error !== 1'b0 || mem_rd !== 1'b1) begin
            errors++; $display("FAIL tmo_wait%0d got err=%b rd=%b exp 0/1", c, fetch_error, mem_rd);
         end
         tick();
      end
      mem_valid = 1'b1;
      #1;
      checks++; if (fetch_error !== 1'b1 || ir_write !== 1'b0) begin
         errors++; $display("FAIL tmo_abort got err=%b wr=%b exp 1/0", fetch_error, ir_write);
      end
      tick();
      mem_valid = 1'b0;
      #1;
      checks++; if (fetch_error !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0040) begin
         errors++; $display("FAIL tmo_after got err=%b busy=%b addr=%h exp 0/0/0040", fetch_error, busy, mem_addr);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_wait_states();
      test_priority();
      test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the memory-wait cycles before abort (used only with FETCH_TIMEOUT_EN).
REQ-002 Port clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Port fetch_req  input  1  SHALL request a two-byte instruction fetch from the current PC.
REQ-005 Port pc_load  input  1  SHALL request a PC overwrite with pc_load_value.
REQ-006 Port pc_load_value  input  16  SHALL be the new PC value.
REQ-007 Port mem_data  input  8  SHALL be the memory read byte.
REQ-008 Port mem_valid  input  1  SHALL indicate mem_data is valid for the current mem_addr.
REQ-009 Port mem_rd  output  1  SHALL be the memory read strobe.
REQ-010 Port mem_addr  output  16  SHALL be the byte address, equal to the PC.
REQ-011 Port ir_write  output  1  SHALL drive the instruction register write enable.
REQ-012 Port ir_high_sel  output  1  SHALL drive the instruction register high-byte select.
REQ-013 Port ir_data  output  8  SHALL drive the instruction register data byte.
REQ-014 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-015 Port fetch_done  output  1  SHALL pulse one cycle when both bytes are written.
REQ-016 Port fetch_error  output  1  SHALL pulse one cycle on timeout abort.

Function
REQ-017 States SHALL be IDLE, REQ_LO, REQ_HI, DONE.
REQ-018 IDLE: pc_load=1 -> pc<=pc_load_value, stay IDLE; else fetch_req=1 -> latch start_pc<=pc, go REQ_LO; pc_load has priority when both asserted.
REQ-019 pc_load and fetch_req SHALL be ignored outside IDLE.
REQ-020 REQ_LO/REQ_HI: mem_rd=1, mem_addr=pc; stay in state while mem_valid=0.
REQ-021 REQ_LO with mem_valid=1: ir_write=1, ir_high_sel=0 combinationally that cycle; pc<=pc+1; go REQ_HI.
REQ-022 REQ_HI with mem_valid=1: ir_write=1, ir_high_sel=1 that cycle; pc<=pc+1; go DONE.
REQ-023 ir_data SHALL equal mem_data combinationally; ir_write SHALL be 0 whenever mem_valid=0 or state is IDLE/DONE.
REQ-024 DONE: fetch_done=1 for exactly one cycle, then IDLE.
REQ-025 Zero-wait memory: fetch_done high in the 3rd cycle after the edge sampling fetch_req.
REQ-026 PC SHALL be 16-bit modulo: 16'hFFFF+1 -> 16'h0000, no flag.
REQ-027 mem_valid outside REQ_LO/REQ_HI SHALL be ignored.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, pc=16'h0000, start_pc=16'h0000, wait counter=0, irrespective of clock.
REQ-029 During and after reset, mem_rd, ir_write, ir_high_sel, busy, fetch_done, fetch_error SHALL be 0; mem_addr=16'h0000.
REQ-030 Reset mid-fetch SHALL abandon the fetch with no fetch_done or fetch_error pulse.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: per-state wait counter clears on entry to REQ_LO/REQ_HI, increments each cycle mem_valid=0; on reaching TIMEOUT_CYCLES -> pc<=start_pc, fetch_error=1 for one cycle, go IDLE, no ir_write that cycle.
REQ-032 Macro FETCH_TIMEOUT_EN undefined: no counter, wait indefinitely, fetch_error tied 0.

Verification
REQ-033 reset pulse, pc_load=1 value 16'h0100, then fetch_req, mem_valid always 1, bytes 8'hA5, 8'h3C -> ir_write low byte then high byte, fetch_done on cycle 3, pc=16'h0102.
REQ-034 pc=16'hFFFF, fetch, zero wait -> mem_addr 16'hFFFF then 16'h0000, final pc=16'h0001.
REQ-035 mem_valid held 0 for 4 cycles in REQ_LO and REQ_HI -> mem_rd high throughout, ir_write only on valid cycles, fetch_done on cycle 11.
REQ-036 pc_load and fetch_req together in IDLE -> pc loaded, busy stays 0; fetch_req while busy -> no second fetch.
REQ-037 reset asserted in REQ_HI -> state IDLE, pc=0, no fetch_done.
REQ-038 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, pc=16'h0040, low byte valid, high byte never valid -> fetch_error after 15 wait cycles, pc=16'h0040, busy=0.
